// File: rtl/led_cube_frame_buffer.sv
// 8x8x8 LED cube frame buffer: UART frame receiver into a back buffer and a
// layer-multiplexed scan-out of the front buffer, swapped at frame boundaries.
module led_cube_frame_buffer #(
  parameter int unsigned LAYER_HOLD = 2000,
  parameter int unsigned RX_TIMEOUT = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] uart_in,
  input  logic       readdatavalid,
  output logic [7:0] Layers_out,
  output logic [7:0] Latches_out,
  output logic [7:0] Data_out,
  output logic [3:0] mode,
  output logic [7:0] frame_count,
  output logic       rx_error
);

  localparam int unsigned HOLD_W = (LAYER_HOLD > 1) ? $clog2(LAYER_HOLD) : 1;
  localparam int unsigned TMO_W  = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LAYER_HOLD - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(RX_TIMEOUT - 1);
  localparam logic [7:0]        HDR_BYTE  = 8'hA5;

  typedef enum logic [1:0] {RX_HDR, RX_LOAD, RX_DISCARD} rx_state_t;
  typedef enum logic [1:0] {SC_BLANK, SC_SETUP, SC_STROBE, SC_HOLD} sc_state_t;

  rx_state_t         r_rx_state;
  logic [5:0]        r_wr_ptr;
  logic [TMO_W-1:0]  r_timer;
  logic [3:0]        r_mode;
  logic [7:0]        r_frame_count;
  logic              r_rx_error;
  logic              r_swap_pending;
  logic              r_front_sel;
  logic [7:0]        r_buf [2][64];

  sc_state_t         r_sc_state;
  logic [2:0]        r_layer;
  logic [2:0]        r_col;
  logic [HOLD_W-1:0] r_hold;
  logic [7:0]        r_layers;
  logic [7:0]        r_latches;
  logic [7:0]        r_data;

  logic              w_load_wr;
  logic              w_frame_done;
  logic              w_swap;
  logic              w_back_sel;
  logic [2:0]        w_rd_col;
  logic [7:0]        w_rd_data;

  assign w_load_wr    = (r_rx_state == RX_LOAD) && readdatavalid;
  assign w_frame_done = w_load_wr && (r_wr_ptr == 6'd63);
  assign w_swap       = (r_sc_state == SC_HOLD) && (r_hold == HOLD_LAST) &&
                        (r_layer == 3'd7) && r_swap_pending;
  assign w_back_sel   = ~r_front_sel;
  // Column to load next: first column when leaving BLANK, else the following one.
  assign w_rd_col     = (r_sc_state == SC_BLANK) ? 3'd0 : (r_col + 3'd1);
  assign w_rd_data    = r_buf[r_front_sel][{r_layer, w_rd_col}];

  // Receive FSM: header/mode decode, payload load or discard, idle timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state    <= RX_HDR;
      r_wr_ptr      <= 6'd0;
      r_timer       <= '0;
      r_mode        <= 4'd0;
      r_frame_count <= 8'd0;
      r_rx_error    <= 1'b0;
    end else begin
      case (r_rx_state)
        RX_HDR: begin
          if (readdatavalid) begin
            if (uart_in == HDR_BYTE) begin
              r_rx_error <= 1'b0;
              r_wr_ptr   <= 6'd0;
              r_timer    <= '0;
              r_rx_state <= r_swap_pending ? RX_DISCARD : RX_LOAD;
            end else if (uart_in[7:4] == 4'h0) begin
              r_mode <= uart_in[3:0];
            end
          end
        end
        RX_LOAD, RX_DISCARD: begin
          if (readdatavalid) begin
            r_timer  <= '0;
            r_wr_ptr <= r_wr_ptr + 6'd1;
            if (r_wr_ptr == 6'd63) begin
              r_rx_state <= RX_HDR;
              if (r_rx_state == RX_LOAD) r_frame_count <= r_frame_count + 8'd1;
            end
          end else if (r_timer == TMO_LAST) begin
            r_rx_state <= RX_HDR;
            r_rx_error <= 1'b1;
          end else begin
            r_timer <= r_timer + TMO_W'(1);
          end
        end
        default: r_rx_state <= RX_HDR;
      endcase
    end
  end

  // A completed frame waits for the layer-7 boundary; a swap on the same edge sees the old flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_swap_pending <= 1'b0;
      r_front_sel    <= 1'b0;
    end else if (w_swap) begin
      r_swap_pending <= 1'b0;
      r_front_sel    <= ~r_front_sel;
    end else if (w_frame_done) begin
      r_swap_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 64; i++) r_buf[b][i] <= 8'h00;
      end
    end else if (w_load_wr) begin
      r_buf[w_back_sel][r_wr_ptr] <= uart_in;
    end
  end

  // Scan-out FSM; outputs are loaded on the edge that enters each state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sc_state <= SC_BLANK;
      r_layer    <= 3'd0;
      r_col      <= 3'd0;
      r_hold     <= '0;
      r_layers   <= 8'd0;
      r_latches  <= 8'd0;
      r_data     <= 8'd0;
    end else begin
      case (r_sc_state)
        SC_BLANK: begin
          r_col      <= 3'd0;
          r_data     <= w_rd_data;
          r_latches  <= 8'd0;
          r_layers   <= 8'd0;
          r_sc_state <= SC_SETUP;
        end
        SC_SETUP: begin
          r_latches  <= 8'd1 << r_col;
          r_sc_state <= SC_STROBE;
        end
        SC_STROBE: begin
          r_latches <= 8'd0;
          if (r_col == 3'd7) begin
            r_layers   <= 8'd1 << r_layer;
            r_hold     <= '0;
            r_sc_state <= SC_HOLD;
          end else begin
            r_col      <= r_col + 3'd1;
            r_data     <= w_rd_data;
            r_sc_state <= SC_SETUP;
          end
        end
        SC_HOLD: begin
          if (r_hold == HOLD_LAST) begin
            r_layers   <= 8'd0;
            r_layer    <= r_layer + 3'd1;
            r_sc_state <= SC_BLANK;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        default: r_sc_state <= SC_BLANK;
      endcase
    end
  end

  assign Layers_out  = r_layers;
  assign Latches_out = r_latches;
  assign Data_out    = r_data;
  assign mode        = r_mode;
  assign frame_count = r_frame_count;
  assign rx_error    = r_rx_error;

endmodule

// File: tb/tb_led_cube_frame_buffer.sv
// Directed bench for led_cube_frame_buffer: scan timing, frame load/swap,
// discard, timeout and reset behaviour against hand-derived expectations.
module tb_led_cube_frame_buffer;

  localparam int unsigned LH  = 4;
  localparam int unsigned TMO = 40;
  localparam int unsigned PER = 17 + LH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] uart_in = 8'h00;
  logic       readdatavalid = 1'b0;
  logic [7:0] Layers_out, Latches_out, Data_out, frame_count;
  logic [3:0] mode;
  logic       rx_error;

  led_cube_frame_buffer #(.LAYER_HOLD(LH), .RX_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .uart_in(uart_in), .readdatavalid(readdatavalid),
    .Layers_out(Layers_out), .Latches_out(Latches_out), .Data_out(Data_out),
    .mode(mode), .frame_count(frame_count), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_f [64];
  logic [7:0] exp_f [64];

  typedef struct {
    logic [7:0] b;
    logic [3:0] exp_mode;
    logic       exp_err;
  } hdr_vec_t;
  hdr_vec_t hdr_vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    readdatavalid = 1'b0;
    uart_in = 8'h00;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_in = b;
    readdatavalid = 1'b1;
    step();
    readdatavalid = 1'b0;
    uart_in = 8'h00;
  endtask

  task automatic send_frame();
    send_byte(8'hA5);
    for (int i = 0; i < 64; i++) send_byte(tx_f[i]);
  endtask

  function automatic logic [7:0] pat(input int sel, input int i);
    case (sel)
      1:       return 8'(i);
      2:       return 8'(i * 7 + 1);
      3:       return 8'(255 - i);
      default: return 8'h00;
    endcase
  endfunction

  task automatic load_tx(input int sel);
    for (int i = 0; i < 64; i++) tx_f[i] = pat(sel, i);
  endtask

  task automatic load_exp(input int sel);
    for (int i = 0; i < 64; i++) exp_f[i] = pat(sel, i);
  endtask

  // Starts at the BLANK cycle of layer 0 and checks one full 8-layer scan.
  task automatic check_scan(input string tag);
    for (int k = 0; k < 8 * PER; k++) begin
      int p = k % PER;
      int l = k / PER;
      logic [7:0] el = 8'h00;
      logic [7:0] ec = 8'h00;
      if (p >= 17) el = 8'd1 << l;
      else if (p >= 1 && (p % 2) == 0) ec = 8'd1 << ((p - 2) / 2);
      chk($sformatf("%s lay/lat k=%0d", tag, k), {16'h0, Layers_out, Latches_out}, {16'h0, el, ec});
      if (p >= 1 && p <= 16)
        chk($sformatf("%s data k=%0d", tag, k), {24'h0, Data_out}, {24'h0, exp_f[l * 8 + (p - 1) / 2]});
      step();
    end
  endtask

  task automatic wait_boundary();
    int n = 0;
    while (Layers_out !== 8'h80 && n < 1000) begin step(); n++; end
    chk("reach layer7", {24'h0, Layers_out}, 32'h80);
    n = 0;
    while (Layers_out !== 8'h00 && n < 50) begin step(); n++; end
    chk("layer7 boundary", {16'h0, Layers_out, Latches_out}, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " layers"}, {24'h0, Layers_out}, 32'h0);
    chk({tag, " latches"}, {24'h0, Latches_out}, 32'h0);
    chk({tag, " data"}, {24'h0, Data_out}, 32'h0);
    chk({tag, " mode"}, {28'h0, mode}, 32'h0);
    chk({tag, " frame_count"}, {24'h0, frame_count}, 32'h0);
    chk({tag, " rx_error"}, {31'h0, rx_error}, 32'h0);
  endtask

  initial begin
    hdr_vecs[0] = '{8'h07, 4'h7, 1'b1};
    hdr_vecs[1] = '{8'h10, 4'h7, 1'b1};
    hdr_vecs[2] = '{8'h0F, 4'hF, 1'b1};
    hdr_vecs[3] = '{8'hA4, 4'hF, 1'b1};
    hdr_vecs[4] = '{8'h00, 4'h0, 1'b1};
    hdr_vecs[5] = '{8'h05, 4'h5, 1'b1};
    hdr_vecs[6] = '{8'hA5, 4'h5, 1'b0};

    @(negedge clk);

    // Idle scan after reset, across the layer 7 -> 0 wrap.
    do_reset();
    chk_all_zero("reset");
    load_exp(0);
    check_scan("idle1");
    check_scan("idle2");

    // Single frame becomes visible after the next layer-7 boundary.
    do_reset();
    load_tx(1);
    send_frame();
    chk("one frame count", {24'h0, frame_count}, 32'd1);
    chk("one frame err", {31'h0, rx_error}, 32'd0);
    load_exp(1);
    wait_boundary();
    check_scan("frame_idx");

    // Second frame while swap still pending is discarded.
    do_reset();
    load_tx(2);
    send_frame();
    load_tx(3);
    send_frame();
    chk("discard count", {24'h0, frame_count}, 32'd1);
    load_exp(2);
    wait_boundary();
    check_scan("discard1");
    check_scan("discard2");
    chk("discard count after", {24'h0, frame_count}, 32'd1);

    // Frame completing on the swap edge waits a full scan.
    do_reset();
    repeat (103) step();
    load_tx(3);
    send_frame();
    chk("late frame count", {24'h0, frame_count}, 32'd1);
    load_exp(0);
    check_scan("late_noswap");
    load_exp(3);
    check_scan("late_swap");

    // Payload timeout, then header-state mode commands.
    do_reset();
    load_tx(1);
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(tx_f[i]);
    repeat (TMO - 2) step();
    send_byte(8'h33);
    chk("no timeout before limit", {31'h0, rx_error}, 32'd0);
    repeat (TMO + 2) step();
    chk("timeout err", {31'h0, rx_error}, 32'd1);
    chk("timeout count", {24'h0, frame_count}, 32'd0);
    repeat (3 * TMO) step();
    chk("hdr no timeout", {31'h0, rx_error}, 32'd1);
    for (int v = 0; v < 7; v++) begin
      send_byte(hdr_vecs[v].b);
      chk($sformatf("hdr mode v=%0d", v), {28'h0, mode}, {28'h0, hdr_vecs[v].exp_mode});
      chk($sformatf("hdr err v=%0d", v), {31'h0, rx_error}, {31'h0, hdr_vecs[v].exp_err});
    end
    for (int i = 0; i < 64; i++) send_byte(tx_f[i]);
    chk("after timeout count", {24'h0, frame_count}, 32'd1);

    // Reset during payload load; next frame must start at index 0.
    do_reset();
    send_byte(8'h05);
    load_tx(2);
    send_byte(8'hA5);
    for (int i = 0; i < 30; i++) send_byte(tx_f[i]);
    rst_n = 1'b0;
    step();
    chk_all_zero("rst mid load");
    rst_n = 1'b1;
    load_tx(2);
    send_frame();
    chk("reload count", {24'h0, frame_count}, 32'd1);
    load_exp(2);
    wait_boundary();
    check_scan("reload");

    // Reset during HOLD with a frame on display clears both buffers.
    do_reset();
    load_tx(1);
    send_frame();
    wait_boundary();
    begin
      int n = 0;
      while (Layers_out === 8'h00 && n < 100) begin step(); n++; end
    end
    chk("in hold", {24'h0, Layers_out}, 32'h01);
    chk("hold data", {24'h0, Data_out}, 32'h07);
    rst_n = 1'b0;
    step();
    chk_all_zero("rst in hold");
    rst_n = 1'b1;
    load_exp(0);
    check_scan("cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/led_cube_frame_buffer.md
LED_CUBE_FRAME_BUFFER -- requirements
Module: led_cube_frame_buffer

Interface
REQ-001 Parameter LAYER_HOLD, default 2000, cycles each layer is held lit (>=1).
REQ-002 Parameter RX_TIMEOUT, default 5000000, max idle cycles between payload bytes (>=1).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 uart_in  input  8  received byte from the UART reader stage.
REQ-006 readdatavalid  input  1  one-cycle strobe; uart_in valid in that cycle.
REQ-007 Layers_out  output  8  one-hot layer enable, 0 = blank.
REQ-008 Latches_out  output  8  one-hot column-latch strobe.
REQ-009 Data_out  output  8  column data bus to latches.
REQ-010 mode  output  4  last mode command received.
REQ-011 frame_count  output  8  count of completed frames, wraps 255->0.
REQ-012 rx_error  output  1  sticky: payload timeout occurred.

Function -- receive
REQ-013 Rx FSM states: HDR, LOAD, DISCARD; byte consumed only in cycles with readdatavalid=1.
REQ-014 HDR: byte 0xA5 with swap_pending=0 -> LOAD, wr_ptr=0; 0xA5 with swap_pending=1 -> DISCARD, wr_ptr=0.
REQ-015 HDR: byte 0x00-0x0F -> mode <= byte[3:0] next cycle, stay HDR; any other byte ignored.
REQ-016 LOAD: byte written to back buffer at index wr_ptr (layer = wr_ptr[5:3], column = wr_ptr[2:0]); wr_ptr increments.
REQ-017 LOAD: write of index 63 -> swap_pending=1, frame_count+1, return HDR.
REQ-018 DISCARD: consume 64 bytes without writing; frame_count unchanged; return HDR.
REQ-019 Rx timer resets on each accepted byte and on entering LOAD/DISCARD; reaching RX_TIMEOUT in LOAD/DISCARD -> HDR, rx_error=1, partial back buffer kept, swap_pending unchanged.
REQ-020 rx_error clears when a 0xA5 header is accepted.
REQ-021 HDR has no timeout.

Function -- scan-out
REQ-022 Scan FSM states: BLANK, SETUP, STROBE, HOLD; counters layer[2:0], col[2:0], hold timer.
REQ-023 BLANK (1 cycle): Layers_out=0, Latches_out=0 -> SETUP, col=0.
REQ-024 SETUP (1 cycle): Data_out = front[layer][col], Latches_out=0 -> STROBE.
REQ-025 STROBE (1 cycle): Latches_out = one-hot(col), Data_out held; col=7 -> HOLD else col+1 -> SETUP.
REQ-026 HOLD: Layers_out = one-hot(layer), Latches_out=0, for exactly LAYER_HOLD cycles -> BLANK, layer+1 (7 wraps to 0).
REQ-027 Layer period = 17 + LAYER_HOLD cycles; Layers_out and Latches_out never both nonzero.
REQ-028 Buffer swap only on HOLD->BLANK transition with layer=7 and swap_pending=1: front/back exchange, swap_pending=0 same edge.
REQ-029 Frame completing on the same edge as the swap point: not swapped this scan; swaps at next layer-7 boundary.
REQ-030 Rx and scan-out run concurrently; scan never reads the back buffer.

Reset
REQ-031 rst_n=0 at a clock edge: Rx->HDR, wr_ptr=0, timer=0, swap_pending=0, mode=0, frame_count=0, rx_error=0.
REQ-032 Reset: scan->BLANK, layer=0, col=0; Layers_out=0, Latches_out=0, Data_out=0.
REQ-033 Reset: both buffers cleared to 0x00; front/back selection returns to buffer A front.
REQ-034 Reset mid-frame or mid-scan aborts immediately; no partial frame is ever displayed.

Verification
REQ-035 Reset, no input, LAYER_HOLD=4 -> Layers_out cycles 01,02,...,80,01 with period 21; Data_out always 0; each layer has 8 Latches_out pulses 01..80.
REQ-036 Send A5 then bytes 0..63 -> frame_count=1; after next layer-7 boundary, layer 2 column 5 strobe shows Data_out=0x15.
REQ-037 Send two full frames back-to-back before the swap point -> second frame discarded, frame_count=1, display shows first frame.
REQ-038 Send A5 + 10 bytes, stall RX_TIMEOUT cycles -> rx_error=1, no swap; then byte 0x07 -> mode=7; then A5 -> rx_error=0.
REQ-039 Assert rst_n=0 during LOAD at wr_ptr=30 and during HOLD -> all outputs 0, frame_count=0, next full frame loads from index 0.
